// File: rtl/cl_evt_propagator_tx.sv
// Cluster-side event transmitter.
// Single-cycle event pulses are counted as pending events. Each pending
// event is delivered to the host-domain receiver with a 4-phase level
// handshake (valid_o / ack_i). The acknowledge is synchronized before use.
// After reset, launches wait until the synchronizer has been refilled from
// ack_i, so a receiver that is still mid-handshake can finish returning
// to zero.

module cl_evt_propagator_tx #(
    parameter int CNT_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 evt_i,
    output logic                 valid_o,
    input  logic                 ack_i,
    output logic [CNT_WIDTH-1:0] pending_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    input  logic                 clr_overflow_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } txState_e;

    localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

    txState_e               r_state;
    txState_e               w_nextState;
    logic [SYNC_STAGES-1:0] r_ackSync;
    logic [SYNC_STAGES-1:0] r_primed;
    logic [CNT_WIDTH-1:0]   r_pending;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_overflow;
    logic                   w_ackSync;
    logic                   w_primed;
    logic                   w_launch;
    logic                   w_nextValid;
    logic                   w_nextBusy;
    logic                   w_setOverflow;

    assign w_ackSync = r_ackSync[SYNC_STAGES-1];
    assign w_primed  = r_primed[SYNC_STAGES-1];

    // Ack synchronizer, plus a chain of ones that marks when it holds real ack_i samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ackSync <= '0;
            r_primed  <= '0;
        end else begin
            r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], ack_i};
            r_primed  <= {r_primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Handshake state register; valid and busy are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_valid <= w_nextValid;
            r_busy  <= w_nextBusy;
        end
    end

    // Next-state logic; leaving IDLE is the launch of one pending event.
    always_comb begin
        w_nextState = r_state;
        w_launch    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if ((r_pending != '0) && !w_ackSync && w_primed) begin
                    w_nextState = REQ;
                    w_launch    = 1'b1;
                end
            end
            REQ: begin
                if (w_ackSync) begin
                    w_nextState = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_ackSync) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode of the next state, captured by the state register.
    always_comb begin
        w_nextValid   = (w_nextState == REQ);
        w_nextBusy    = (w_nextState != IDLE);
        w_setOverflow = evt_i && !w_launch && (r_pending == PEND_MAX);
    end

    // Pending counter: an event and a launch in the same cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else if (evt_i && !w_launch) begin
            if (r_pending != PEND_MAX) begin
                r_pending <= r_pending + 1'b1;
            end
        end else if (!evt_i && w_launch) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    // Sticky overflow; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (w_setOverflow) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign valid_o    = r_valid;
    assign busy_o     = r_busy;
    assign pending_o  = r_pending;
    assign overflow_o = r_overflow;

endmodule
